// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the in-order pipeline hazard scoreboard.
package hazard_scoreboard_pkg;

  // Entry rd storage is sized for the widest supported register address.
  localparam int MAX_REG_ADDR_W = 8;
  localparam int CNT_W_DEF      = 32;
  localparam int FWD_RF         = 0;

  typedef struct packed {
    logic                      valid;
    logic [MAX_REG_ADDR_W-1:0] rd;
    logic                      we;
    logic                      is_load;
  } entry_t;

  function automatic int fwd_sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Per-source youngest-match priority encoder over the in-flight entries.
module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = 2
) (
  input  logic [DEPTH-1:0]                entry_valid,
  input  logic [DEPTH-1:0]                entry_we,
  input  logic [DEPTH-1:0]                entry_load,
  input  logic [DEPTH*MAX_REG_ADDR_W-1:0] entry_rd,
  input  logic [REG_ADDR_W-1:0]           rs,
  input  logic                            rs_used,
  output logic [SEL_W-1:0]                fwd_sel,
  output logic                            load_hazard
);

  logic [MAX_REG_ADDR_W-1:0] rs_ext_s;
  logic                      rs_live_s;

  // Walk oldest to youngest so the youngest matching entry has the final say.
  always_comb begin
    rs_ext_s    = MAX_REG_ADDR_W'(rs);
    rs_live_s   = rs_used && (rs != '0);
    fwd_sel     = SEL_W'(FWD_RF);
    load_hazard = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rs_live_s && entry_valid[i] && entry_we[i] &&
          (entry_rd[i*MAX_REG_ADDR_W +: MAX_REG_ADDR_W] == rs_ext_s)) begin
        fwd_sel     = SEL_W'(i + 1);
        load_hazard = entry_load[i] && (i < LOAD_LAT);
      end else begin
        fwd_sel     = fwd_sel;
        load_hazard = load_hazard;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination registers, raises load-use stalls and
// selects forwarding sources; counts stall and flush cycles.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = CNT_W_DEF,
  localparam int SEL_W     = fwd_sel_w(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_valid_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_i,
  input  logic [NUM_SRC-1:0]            rs_used_i,
  input  logic [REG_ADDR_W-1:0]         rd_i,
  input  logic                          rd_we_i,
  input  logic                          is_load_i,
  input  logic                          flush_i,
  output logic                          stall_o,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o,
  output logic [CNT_W-1:0]              stall_cnt_o,
  output logic [CNT_W-1:0]              flush_cnt_o
);

  entry_t                          entry_r [DEPTH];
  logic [CNT_W-1:0]                stall_cnt_r;
  logic [CNT_W-1:0]                flush_cnt_r;
  logic [DEPTH-1:0]                valid_s;
  logic [DEPTH-1:0]                we_s;
  logic [DEPTH-1:0]                load_s;
  logic [DEPTH*MAX_REG_ADDR_W-1:0] rd_s;
  logic [NUM_SRC-1:0]              hazard_s;
  logic                            stall_s;
  logic                            issue_s;

  // Flatten the entry array into per-field vectors for the match encoders.
  always_comb begin
    valid_s = '0;
    we_s    = '0;
    load_s  = '0;
    rd_s    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_s[i]                                = entry_r[i].valid;
      we_s[i]                                   = entry_r[i].we;
      load_s[i]                                 = entry_r[i].is_load;
      rd_s[i*MAX_REG_ADDR_W +: MAX_REG_ADDR_W] = entry_r[i].rd;
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    hazard_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .DEPTH      (DEPTH),
      .LOAD_LAT   (LOAD_LAT),
      .SEL_W      (SEL_W)
    ) u_match (
      .entry_valid (valid_s),
      .entry_we    (we_s),
      .entry_load  (load_s),
      .entry_rd    (rd_s),
      .rs          (rs_i[s*REG_ADDR_W +: REG_ADDR_W]),
      .rs_used     (rs_used_i[s]),
      .fwd_sel     (fwd_sel_o[s*SEL_W +: SEL_W]),
      .load_hazard (hazard_s[s])
    );
  end

  // A flush kills the decode instruction, so it can neither stall nor issue.
  always_comb begin
    stall_s = issue_valid_i && !flush_i && (|hazard_s);
    issue_s = issue_valid_i && !flush_i && !stall_s;
  end

  // Advance the in-flight window, insert the issued instruction or a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '0;
      end
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        entry_r[i] <= entry_r[i-1];
      end
      if (issue_s) begin
        entry_r[0] <= '{valid:   1'b1,
                        rd:      MAX_REG_ADDR_W'(rd_i),
                        we:      rd_we_i,
                        is_load: is_load_i};
      end else begin
        entry_r[0] <= '0;
      end
    end
  end

  // Saturating stall and flush cycle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (stall_s && (stall_cnt_r != '1)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_i && (flush_cnt_r != '1)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_o     = stall_s;
  assign stall_cnt_o = stall_cnt_r;
  assign flush_cnt_o = flush_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard (DEPTH=3, LOAD_LAT=1, CNT_W=4).
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       issue_valid_i;
  logic [9:0] rs_i;
  logic [1:0] rs_used_i;
  logic [4:0] rd_i;
  logic       rd_we_i;
  logic       is_load_i;
  logic       flush_i;
  logic       stall_o;
  logic [3:0] fwd_sel_o;
  logic [3:0] stall_cnt_o;
  logic [3:0] flush_cnt_o;

  int check_cnt = 0;
  int pass_cnt  = 0;

  hazard_scoreboard #(
    .REG_ADDR_W (5),
    .NUM_SRC    (2),
    .DEPTH      (3),
    .LOAD_LAT   (1),
    .CNT_W      (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_i (issue_valid_i),
    .rs_i          (rs_i),
    .rs_used_i     (rs_used_i),
    .rd_i          (rd_i),
    .rd_we_i       (rd_we_i),
    .is_load_i     (is_load_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .fwd_sel_o     (fwd_sel_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [1:0] used, input logic [4:0] rd, input logic we,
                       input logic ld, input logic fl);
    issue_valid_i = v;
    rs_i          = {r1, r0};
    rs_used_i     = used;
    rd_i          = rd;
    rd_we_i       = we;
    is_load_i     = ld;
    flush_i       = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_stall", 32'(stall_o), 32'd0);
    chk("reset_fwd0", 32'(fwd_sel_o[1:0]), 32'd0);
    chk("reset_fwd1", 32'(fwd_sel_o[3:2]), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt_o), 32'd0);
    chk("reset_flush_cnt", 32'(flush_cnt_o), 32'd0);

    // add x5, then read x5 on rs1
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("alu_fwd_stall", 32'(stall_o), 32'd0);
    chk("alu_fwd_sel0", 32'(fwd_sel_o[1:0]), 32'd1);
    tick();

    // lw x6, then read x6 on rs2: one stall cycle, then forward from entry 1
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd6, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("loaduse_stall", 32'(stall_o), 32'd1);
    chk("loaduse_fwd1_during_stall", 32'(fwd_sel_o[3:2]), 32'd1);
    tick();
    chk("loaduse_stall_released", 32'(stall_o), 32'd0);
    chk("loaduse_fwd1", 32'(fwd_sel_o[3:2]), 32'd2);
    chk("loaduse_stall_cnt", 32'(stall_cnt_o), 32'd1);
    tick();

    // two writes to x7, youngest wins on both sources
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 5'd7, 5'd7, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("youngest_fwd0", 32'(fwd_sel_o[1:0]), 32'd1);
    chk("youngest_fwd1", 32'(fwd_sel_o[3:2]), 32'd1);
    chk("youngest_stall", 32'(stall_o), 32'd0);
    tick();

    // load writing x0 never matches
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("x0_fwd0", 32'(fwd_sel_o[1:0]), 32'd0);
    chk("x0_fwd1", 32'(fwd_sel_o[3:2]), 32'd0);
    chk("x0_stall", 32'(stall_o), 32'd0);
    tick();

    // lw x8 in E, dependent decode killed by flush
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd8, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0, 1'b1);
    chk("flush_stall", 32'(stall_o), 32'd0);
    chk("flush_fwd0", 32'(fwd_sel_o[1:0]), 32'd1);
    tick();
    drive(1'b1, 5'd8, 5'd9, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("flush_cnt", 32'(flush_cnt_o), 32'd1);
    chk("flush_after_fwd0", 32'(fwd_sel_o[1:0]), 32'd2);
    chk("flush_bubble_fwd1", 32'(fwd_sel_o[3:2]), 32'd0);
    chk("flush_after_stall", 32'(stall_o), 32'd0);
    tick();

    // no valid instruction: no stall and a bubble
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 5'd10, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("novalid_stall", 32'(stall_o), 32'd0);
    chk("novalid_fwd0", 32'(fwd_sel_o[1:0]), 32'd1);
    tick();
    drive(1'b1, 5'd10, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("novalid_bubble_fwd0", 32'(fwd_sel_o[1:0]), 32'd2);
    chk("stall_cnt_unchanged", 32'(stall_cnt_o), 32'd1);
    tick();

    // reset in the middle of a stall
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd11, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("midrst_stall_before", 32'(stall_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_stall_after", 32'(stall_o), 32'd0);
    chk("midrst_fwd0", 32'(fwd_sel_o[1:0]), 32'd0);
    chk("midrst_stall_cnt", 32'(stall_cnt_o), 32'd0);
    chk("midrst_flush_cnt", 32'(flush_cnt_o), 32'd0);
    tick();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();

    // self-dependent lw x12 held in decode: issue, stall, issue, stall, ...
    drive(1'b1, 5'd12, 5'd0, 2'b01, 5'd12, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("stall_cnt_10_edges", 32'(stall_cnt_o), 32'd5);
    for (int i = 0; i < 40; i++) tick();
    chk("stall_cnt_saturated", 32'(stall_cnt_o), 32'd15);

    // flush counter saturation
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    chk("flush_cnt_10", 32'(flush_cnt_o), 32'd10);
    for (int i = 0; i < 10; i++) tick();
    chk("flush_cnt_saturated", 32'(flush_cnt_o), 32'd15);
    chk("stall_cnt_held", 32'(stall_cnt_o), 32'd15);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL take parameter REG_ADDR_W, default 5: register-address width.
REQ-002 SHALL take parameter NUM_SRC, default 2: source operands checked per instruction.
REQ-003 SHALL take parameter DEPTH, default 3: tracked in-flight stages; entry 0=E, entry DEPTH-1=W.
REQ-004 SHALL take parameter LOAD_LAT, default 1: load data is forwardable only from entries with index >= LOAD_LAT.
REQ-005 SHALL take parameter CNT_W, default 32: performance-counter width.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 issue_valid_i  input  1  decode holds a valid instruction.
REQ-009 rs_i  input  NUM_SRC x REG_ADDR_W  source register addresses.
REQ-010 rs_used_i  input  NUM_SRC  per-source "operand is read" flag.
REQ-011 rd_i  input  REG_ADDR_W  destination register address.
REQ-012 rd_we_i  input  1  instruction writes rd.
REQ-013 is_load_i  input  1  instruction is a load.
REQ-014 flush_i  input  1  taken branch/jump resolved in E; kill decode instruction.
REQ-015 stall_o  output  1  hold F/D registers this cycle.
REQ-016 fwd_sel_o  output  NUM_SRC x clog2(DEPTH+1)  0=register file, k=forward from entry k-1.
REQ-017 stall_cnt_o  output  CNT_W  stall cycles counted.
REQ-018 flush_cnt_o  output  CNT_W  flush cycles counted.

Function
REQ-019 SHALL keep DEPTH entries {valid, rd, we, is_load}; an entry "matches" source s when valid, we, rd!=0, rd==rs_i[s], rs_used_i[s].
REQ-020 SHALL never match register 0, whatever we or rd_we_i.
REQ-021 stall_o SHALL be combinational: 1 iff issue_valid_i, !flush_i, and some source's youngest matching entry i is a load with i < LOAD_LAT.
REQ-022 fwd_sel_o[s] SHALL be combinational: youngest (lowest-index) match i gives i+1; no match gives 0; youngest wins when several entries match.
REQ-023 SHALL compute fwd_sel_o regardless of stall_o; consumers ignore it while stall_o=1.
REQ-024 Each edge, SHALL shift entry[i] to entry[i+1] for all i; entry DEPTH-1 is discarded.
REQ-025 Each edge, entry 0 SHALL load {1, rd_i, rd_we_i, is_load_i} iff issue_valid_i & !stall_o & !flush_i; otherwise a bubble (valid=0).
REQ-026 flush_i SHALL take priority over stall_o: stall_o=0 and a bubble is inserted while flush_i=1.
REQ-027 flush_i SHALL NOT invalidate entries 0..DEPTH-1 (the branch in E and older instructions complete).
REQ-028 stall_cnt_o SHALL increment by 1 on each edge where stall_o=1, saturating at all-ones.
REQ-029 flush_cnt_o SHALL increment by 1 on each edge where flush_i=1, saturating at all-ones.
REQ-030 With issue_valid_i=0, stall_o SHALL be 0 and a bubble is inserted.

Reset
REQ-031 On a clk edge with rst=1, all entries SHALL clear to valid=0 and both counters to 0, overriding all other inputs.
REQ-032 Out of reset, stall_o=0 and all fwd_sel_o=0 until an instruction is issued.
REQ-033 rst asserted mid-stall SHALL drop stall_o the cycle after, since no loads remain tracked.

Structure
REQ-034 A shared package SHALL hold the entry struct typedef, the fwd_sel encoding constants (FWD_RF=0) and the counter-width default.
REQ-035 One sub-module SHALL be natural: hazard_match, the per-source youngest-match priority encoder, instantiated NUM_SRC times.
REQ-036 SHALL be parametrisation-safe for DEPTH 2..6 and NUM_SRC 1..3.

Verification
REQ-037 Issue add x5 (rd_we=1), next cycle rs1=x5 -> stall_o=0, fwd_sel_o[0]=1.
REQ-038 Issue lw x6, next cycle rs2=x6 -> stall_o=1 for 1 cycle, then fwd_sel_o[1]=2, stall_cnt_o=1.
REQ-039 Issue writes to x7 in two consecutive cycles, then read x7 -> fwd_sel_o=1 (youngest wins), not 2.
REQ-040 Issue rd=x0 with we=1, then read x0 -> fwd_sel_o=0, stall_o=0.
REQ-041 lw x8 in E, decode reads x8, with flush_i=1 the same cycle -> stall_o=0, bubble inserted, flush_cnt_o=1, following cycle no match on x8 from entry 0.
REQ-042 Stall in progress, rst=1 for one edge -> entries invalid, counters 0, stall_o=0 next cycle; with CNT_W=4, 20 stall cycles -> stall_cnt_o holds 15.
